router_pkt_reader: RTL and testbench

- Drains one router output FIFO. Each 9-bit FIFO word is {hdr_flag, byte}.
- Re-frames the words into packets and presents them on a valid/ready byte interface toward the destination port.
- Checks packet length and parity.
- Generates the soft_reset that flushes the FIFO when the destination stalls too long.
- One instance sits between each of the three FIFOs and its output port.

---
 rtl/router_pkg.sv | 12 +
 rtl/router_skid_buf.sv | 40 ++++
 rtl/router_pkt_reader.sv | 102 ++++++++++
 tb/tb_router_pkt_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared FSM state type, header field positions and defaults
// for the router packet reader.
package router_pkg;
    typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY} state_e;
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;
    localparam int LEN_W        = HDR_LEN_MSB - HDR_LEN_LSB + 1;
    localparam int FIFO_W       = 9;
    localparam int DEF_TIMEOUT  = 30;
endpackage

// File: rtl/router_skid_buf.sv
// router_skid_buf: 2-entry valid/ready buffer with a synchronous flush;
// the head entry is held stable while out_rdy is low.
module router_skid_buf #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    input  logic         out_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d, cnt_p;
    logic         pop;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end
    always_comb begin
        pop   = (cnt_q != 2'd0) & out_rdy;
        cnt_p = cnt_q - {1'b0, pop};
        e0_d  = (in_vld && cnt_p == 2'd0) ? in_data : (pop ? e1_q : e0_q);
        e1_d  = (in_vld && cnt_p == 2'd1) ? in_data : e1_q;
        cnt_d = flush ? 2'd0 : cnt_p + {1'b0, in_vld};
    end
    assign out_vld  = cnt_q != 2'd0;
    assign out_data = e0_q;
    assign count    = cnt_q;
endmodule

// File: rtl/router_pkt_reader.sv
// router_pkt_reader: drains one router FIFO, re-frames packets onto a valid/ready
// byte port, flags framing/parity errors and issues a stall soft_reset. ROUTER_PARITY_CHECK_EN enables parity checking.
module router_pkt_reader
    import router_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TMO_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [FIFO_W-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic              soft_reset,
    input  logic              ready_in,
    output logic              vld_out,
    output logic [DATA_W-1:0] data_out,
    output logic              sop,
    output logic              eop,
    output logic              parity_err,
    output logic              frm_err
);
    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               rdf_q, rdf_d, disc_q, disc_d;
    logic               flag, word, push, xfer;
    logic [DATA_W-1:0]  byte_in;
    logic [LEN_W-1:0]   hdr_len;
    logic [DATA_W+1:0]  push_data;
    logic [1:0]         occ;
    logic [2:0]         need;
`ifdef ROUTER_PARITY_CHECK_EN
    logic [DATA_W-1:0]  par_q, par_d;
`endif
    assign flag    = fifo_rdata[FIFO_W-1];
    assign byte_in = fifo_rdata[DATA_W-1:0];
    assign hdr_len = fifo_rdata[HDR_LEN_MSB:HDR_LEN_LSB];
    assign xfer    = vld_out & ready_in;
    // a word returning during soft_reset is dropped with the flush
    assign word       = rdf_q & ~soft_reset;
    assign soft_reset = tmo_q == TMO_W'(TIMEOUT - 1);
    // count the byte leaving this cycle as free so a full-rate stream never bubbles
    assign need       = {1'b0, occ} + {2'b00, rdf_q} - {2'b00, xfer};
    assign fifo_rd_en = ~reset & ~fifo_empty & ~soft_reset & (need < 3'd2);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            tmo_q   <= '0;
            rdf_q   <= 1'b0;
            disc_q  <= 1'b0;
`ifdef ROUTER_PARITY_CHECK_EN
            par_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            tmo_q   <= tmo_d;
            rdf_q   <= rdf_d;
            disc_q  <= disc_d;
`ifdef ROUTER_PARITY_CHECK_EN
            par_q   <= par_d;
`endif
        end
    end
    always_comb begin
        state_d = soft_reset ? IDLE :
                  !word ? state_q :
                  flag ? ((hdr_len == '0) ? PARITY : PAYLOAD) :
                  (state_q == PAYLOAD) ? ((len_q == LEN_W'(1)) ? PARITY : PAYLOAD) :
                  IDLE;
    end
    always_comb begin
        push      = word & (flag | (state_q != IDLE));
        push_data = {flag, (state_q == PARITY) & ~flag, byte_in};
        frm_err   = word & (flag ? (state_q != IDLE) : ((state_q == IDLE) & ~disc_q));
        len_d     = (word & flag) ? hdr_len :
                    (word & (state_q == PAYLOAD)) ? len_q - LEN_W'(1) : len_q;
        disc_d    = soft_reset ? 1'b0 : word ? ((state_q == IDLE) & ~flag) : disc_q;
        tmo_d     = (soft_reset | ~vld_out | ready_in) ? '0 : tmo_q + TMO_W'(1);
        rdf_d     = fifo_rd_en;
`ifdef ROUTER_PARITY_CHECK_EN
        par_d      = !word ? par_q : flag ? byte_in : par_q ^ byte_in;
        parity_err = word & (state_q == PARITY) & ~flag & (byte_in != par_q);
`else
        parity_err = 1'b0;
`endif
    end
    router_skid_buf #(.W(DATA_W + 2)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (soft_reset),
        .in_vld   (push),
        .in_data  (push_data),
        .out_rdy  (ready_in),
        .out_vld  (vld_out),
        .out_data ({sop, eop, data_out}),
        .count    (occ)
    );
endmodule

// File: tb/tb_router_pkt_reader.sv
// tb_router_pkt_reader: scenario tasks plus a randomized packet stream checked
// against a packet-grammar model; honours ROUTER_PARITY_CHECK_EN.
module tb_router_pkt_reader;
    localparam int TMO = 30;
    logic clk = 1'b0, reset = 1'b1, ready_in = 1'b0;
    logic fifo_empty, fifo_rd_en, soft_reset, vld_out, sop, eop, parity_err, frm_err;
    logic [8:0] fifo_rdata = '0;
    logic [7:0] data_out;
    logic [8:0] mem [0:4095];
    int wp = 0, rp = 0, cyc = 0, frm_cnt = 0, perr_cnt = 0, total = 0, bad = 0;
    bit flush_req = 1'b0;
    logic [9:0] got [$];
    int xcyc [$];

    router_pkt_reader dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_rd_en(fifo_rd_en), .soft_reset(soft_reset), .ready_in(ready_in),
        .vld_out(vld_out), .data_out(data_out), .sop(sop), .eop(eop),
        .parity_err(parity_err), .frm_err(frm_err)
    );

    always #5 clk = ~clk;
    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flush_req || soft_reset) rp <= wp;
        else if (fifo_rd_en && rp != wp) begin
            fifo_rdata <= mem[rp];
            rp <= rp + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (vld_out && ready_in && !soft_reset) begin
                got.push_back({sop, eop, data_out});
                xcyc.push_back(cyc);
            end
            frm_cnt  <= frm_cnt + int'(frm_err);
            perr_cnt <= perr_cnt + int'(parity_err);
        end
    end

    task automatic put(input logic [8:0] w);
        mem[wp] = w;
        wp = wp + 1;
    endtask

    // expected output from the packet grammar: header, L payload bytes, parity byte
    task automatic model(input logic [8:0] w[$], output logic [9:0] e[$], output int nf, output int np);
        int i, len;
        logic [7:0] par;
        bit cut;
        e.delete(); nf = 0; np = 0; i = 0;
        while (i < w.size()) begin
            if (!w[i][8]) begin
                nf++;
                while (i < w.size() && !w[i][8]) i++;
            end else begin
                par = w[i][7:0];
                len = int'(w[i][7:2]);
                e.push_back({2'b10, w[i][7:0]});
                i++; cut = 0;
                for (int k = 0; k < len && i < w.size() && !cut; k++) begin
                    if (w[i][8]) cut = 1;
                    else begin
                        e.push_back({2'b00, w[i][7:0]});
                        par ^= w[i][7:0];
                        i++;
                    end
                end
                if (i < w.size() && !cut && w[i][8]) cut = 1;
                if (cut) nf++;
                else if (i < w.size()) begin
                    e.push_back({2'b01, w[i][7:0]});
                    if (w[i][7:0] != par) np++;
                    i++;
                end
            end
        end
`ifndef ROUTER_PARITY_CHECK_EN
        np = 0;
`endif
    endtask

    task automatic run_until(input int n, input bit rnd, output bit ok);
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            ready_in = rnd ? ($urandom_range(3) != 0) : 1'b1;
            if (got.size() >= n) begin ok = 1; break; end
        end
        repeat (6) begin @(posedge clk); #1 ready_in = 1'b1; end
    endtask

    task automatic test_stream(input string nm, input logic [8:0] w[$], input bit rnd);
        logic [9:0] e[$];
        int nf, np, base, f0, p0, nerr, fi;
        bit ok;
        base = got.size(); f0 = frm_cnt; p0 = perr_cnt;
        model(w, e, nf, np);
        foreach (w[i]) put(w[i]);
        run_until(base + e.size(), rnd, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL %s wait: got %0d bytes, want %0d", nm, got.size() - base, e.size()); end
        total++;
        if (got.size() - base != e.size()) begin bad++; $display("FAIL %s count: got %0d want %0d", nm, got.size() - base, e.size()); end
        nerr = 0; fi = -1;
        for (int i = 0; i < e.size() && base + i < got.size(); i++)
            if (got[base + i] !== e[i]) begin nerr++; if (fi < 0) fi = i; end
        total++;
        if (nerr != 0) begin
            bad++;
            $display("FAIL %s bytes: %0d wrong, first #%0d got %h want %h", nm, nerr, fi, got[base + fi], e[fi]);
        end
        total++;
        if (frm_cnt - f0 != nf) begin bad++; $display("FAIL %s frm_err: got %0d pulses want %0d", nm, frm_cnt - f0, nf); end
        total++;
        if (perr_cnt - p0 != np) begin bad++; $display("FAIL %s parity_err: got %0d pulses want %0d", nm, perr_cnt - p0, np); end
    endtask

    task automatic test_reset;
        put(9'h10D);
        @(negedge clk);
        total++;
        if ({fifo_rd_en, soft_reset, vld_out, data_out, sop, eop, parity_err, frm_err} !== 15'd0) begin
            bad++; $display("FAIL reset_outs: got %h want 0", {fifo_rd_en, soft_reset, vld_out, data_out, sop, eop, parity_err, frm_err});
        end
        flush_req = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0; flush_req = 0;
        @(negedge clk);
        total++;
        if ({fifo_rd_en, vld_out} !== 2'b00) begin bad++; $display("FAIL reset_idle: got %b want 00", {fifo_rd_en, vld_out}); end
    endtask

    task automatic test_clean;
        logic [8:0] w[$] = '{9'h10D, 9'h011, 9'h022, 9'h033, 9'h00D};
        int base = got.size();
        test_stream("clean", w, 0);
        total++;
        if (got.size() < base + 5 || got[base] !== 10'h20D || got[base + 4] !== 10'h10D) begin
            bad++; $display("FAIL clean_ends: got %0d bytes, want 20d..10d", got.size() - base);
        end else begin
            total++;
            if (xcyc[base + 4] - xcyc[base] != 4) begin bad++; $display("FAIL clean_rate: got %0d cycles want 4", xcyc[base + 4] - xcyc[base]); end
        end
    endtask

    task automatic test_parity_err;
        logic [8:0] w[$] = '{9'h10D, 9'h011, 9'h022, 9'h033, 9'h00C};
        int base = got.size();
        test_stream("parity", w, 0);
        total++;
        if (got.size() < base + 5 || got[base + 4] !== 10'h10C) begin bad++; $display("FAIL parity_eop: got %0d bytes, want last 10c", got.size() - base); end
    endtask

    task automatic test_framing;
        logic [8:0] w[$] = '{9'h10D, 9'h011, 9'h104, 9'h055, 9'h051};
        int base = got.size();
        test_stream("framing", w, 0);
        total++;
        if (got.size() < base + 3 || got[base + 2] !== 10'h204) begin bad++; $display("FAIL framing_sop: got %0d bytes, want 204 at #2", got.size() - base); end
    endtask

    task automatic test_backpressure;
        logic [8:0] w[$];
        logic [9:0] e[$];
        logic [10:0] snap;
        logic [7:0] par, b;
        int base, nf, np, nerr;
        bit ok;
        base = got.size(); ready_in = 1;
        w.push_back(9'h129); par = 8'h29;
        for (int i = 0; i < 10; i++) begin b = 8'($urandom); w.push_back({1'b0, b}); par ^= b; end
        w.push_back({1'b0, par});
        model(w, e, nf, np);
        foreach (w[i]) put(w[i]);
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (got.size() >= base + 2) begin ok = 1; break; end
        end
        ready_in = 0;
        @(negedge clk);
        snap = {vld_out, sop, eop, data_out};
        total++;
        if (!ok || snap[10] !== 1'b1) begin bad++; $display("FAIL bp_start: got vld=%b want 1", snap[10]); end
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            total++;
            if ({vld_out, sop, eop, data_out} !== snap) begin bad++; $display("FAIL bp_hold: got %h want %h", {vld_out, sop, eop, data_out}, snap); end
            total++;
            if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL bp_rd_en: got %b want 0 on stall %0d", fifo_rd_en, i); end
        end
        run_until(base + e.size(), 0, ok);
        total++;
        if (!ok || got.size() - base != e.size()) begin bad++; $display("FAIL bp_count: got %0d want %0d", got.size() - base, e.size()); end
        nerr = 0;
        for (int i = 0; i < e.size() && base + i < got.size(); i++) if (got[base + i] !== e[i]) nerr++;
        total++;
        if (nerr != 0) begin bad++; $display("FAIL bp_bytes: got %0d wrong want 0", nerr); end
    endtask

    task automatic test_timeout;
        logic [8:0] w[$] = '{9'h104, 9'h077, 9'h073};
        int n = 0, base;
        bit seen = 0;
        ready_in = 0;
        base = got.size();
        put(9'h1A0);
        for (int i = 0; i < 41; i++) put(9'(i));
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (vld_out && !ready_in) n++;
            total++;
            if (soft_reset !== (n == TMO)) begin
                bad++; seen = 1;
                $display("FAIL timeout_pulse: got soft_reset=%b want %b at stall %0d", soft_reset, n == TMO, n);
            end else if (soft_reset) seen = 1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL timeout_wait: got no soft_reset want one at stall %0d", TMO); end
        @(negedge clk);
        total++;
        if (vld_out !== 1'b0) begin bad++; $display("FAIL timeout_flush: got vld_out=%b want 0", vld_out); end
        total++;
        if (got.size() != base) begin bad++; $display("FAIL timeout_leak: got %0d bytes want 0", got.size() - base); end
        test_stream("after_timeout", w, 0);
    endtask

    task automatic test_reset_mid;
        logic [8:0] w[$] = '{9'h10D, 9'h011, 9'h022, 9'h033, 9'h00D};
        int base = got.size();
        ready_in = 1;
        put(9'h152);
        for (int i = 0; i < 21; i++) put(9'(8'($urandom)));
        for (int c = 0; c < 100 && got.size() < base + 3; c++) @(posedge clk);
        @(negedge clk);
        #2 reset = 1;
        #1;
        total++;
        if ({fifo_rd_en, soft_reset, vld_out, data_out, sop, eop, parity_err, frm_err} !== 15'd0) begin
            bad++; $display("FAIL reset_mid: got %h want 0", {fifo_rd_en, soft_reset, vld_out, data_out, sop, eop, parity_err, frm_err});
        end
        flush_req = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0; flush_req = 0;
        test_stream("after_reset", w, 0);
    endtask

    task automatic test_random;
        logic [8:0] w[$];
        logic [7:0] hdr, par, b;
        int len, keep;
        bit prev_ok = 1, cut;
        for (int p = 0; p < 30; p++) begin
            if (prev_ok && $urandom_range(4) == 0)
                repeat ($urandom_range(1, 3)) w.push_back({1'b0, 8'($urandom)});
            len = (p == 7) ? 63 : int'($urandom_range(0, 12));
            hdr = {len[5:0], 2'($urandom)};
            w.push_back({1'b1, hdr});
            par = hdr;
            cut = (p != 29) && ($urandom_range(6) == 0);
            keep = cut ? int'($urandom_range(0, len)) : len;
            for (int k = 0; k < keep; k++) begin b = 8'($urandom); w.push_back({1'b0, b}); par ^= b; end
            if (!cut) w.push_back({1'b0, par ^ (($urandom_range(4) == 0) ? 8'h5A : 8'h00)});
            prev_ok = !cut;
        end
        test_stream("random", w, 1);
    endtask

    initial begin
        test_reset;
        test_clean;
        test_parity_err;
        test_backpressure;
        test_framing;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want end before 500000");
        $fatal(1, "watchdog");
    end
endmodule
